// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types and default sizes for the data-cache write-back buffer.
// No logic here; latency: n/a.
// Backpressure: n/a.
package dcache_wb_buffer_pkg;

    localparam int DCACHE_ADDR_WIDTH  = 32;
    localparam int DCACHE_LINE_WIDTH  = 128;
    localparam int DCACHE_OFFSET_BITS = 4;
    localparam int DCACHE_WB_DEPTH    = 4;

    typedef struct packed {
        logic                                          valid;
        logic [DCACHE_ADDR_WIDTH-DCACHE_OFFSET_BITS-1:0] line_addr;
        logic [DCACHE_LINE_WIDTH-1:0]                  data;
    } type_wb_entry_s;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WRITE,
        WB_READ
    } type_wb_state_e;

endpackage

// File: rtl/dcache_wb_buffer_match.sv
// Line-address CAM over the buffer entries; reports the youngest match relative to tail.
// Latency: purely combinational.
// Backpressure: none.
module dcache_wb_match
    import dcache_wb_buffer_pkg::*;
#(
    parameter int DEPTH = DCACHE_WB_DEPTH,
    parameter int LA_W  = DCACHE_ADDR_WIDTH - DCACHE_OFFSET_BITS,
    parameter int PTR_W = $clog2(DCACHE_WB_DEPTH)
) (
    input  logic [DEPTH-1:0]      valid,
    input  logic [DEPTH*LA_W-1:0] line_addrs,
    input  logic [PTR_W-1:0]      tail,
    input  logic [LA_W-1:0]       key,
    output logic                  hit,
    output logic [PTR_W-1:0]      idx
);

    // Walk from oldest (tail) to youngest (tail-1); the last match wins.
    always_comb begin
        logic [PTR_W-1:0] j;
        hit = 1'b0;
        idx = '0;
        j   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            j = tail + PTR_W'(k);
            if (valid[j] && (line_addrs[int'(j)*LA_W +: LA_W] == key)) begin
                hit = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer: queues evicted lines, drains them to memory, forwards hits to fills.
// Latency: fill hit 1 cycle after rd_req_i; memory ops registered, one per 2 cycles max.
// Backpressure: full_o drops pushes; drain_i holds off fills. Optional: DCACHE_WB_COALESCE_EN.
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter int WB_DEPTH    = DCACHE_WB_DEPTH,
    parameter int ADDR_W      = DCACHE_ADDR_WIDTH,
    parameter int LINE_W      = DCACHE_LINE_WIDTH,
    parameter int OFFSET_BITS = DCACHE_OFFSET_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [LINE_W-1:0] push_data_i,
    output logic              full_o,
    output logic              empty_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [LINE_W-1:0] rd_data_o,
    output logic              rd_fwd_o,
    input  logic              drain_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int LA_W  = ADDR_W - OFFSET_BITS;
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WB_DEPTH-1:0]      ent_vld;
    logic [WB_DEPTH*LA_W-1:0] ent_la;
    logic [LINE_W-1:0]        ent_dat [WB_DEPTH];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [CNT_W-1:0]         count;

    type_wb_state_e state;
    type_wb_state_e state_nxt;
    logic           start_wr;
    logic           start_rd;
    logic           wr_done;
    logic           rd_done;

    logic            pend_vld;
    logic [LA_W-1:0] pend_la;

    logic [LA_W-1:0] push_la;
    logic [LA_W-1:0] rd_la;
    logic [LA_W-1:0] head_la;
    logic            push_alloc;
    logic            push_merge;
    logic            coal_hit;

    logic             buf_hit;
    logic [PTR_W-1:0] buf_idx;
    logic             rd_take;
    logic             push_fwd;
    logic             rd_hit;
    logic [LINE_W-1:0] fwd_dat;

    logic unused_offset_bits;

    assign push_la = push_addr_i[ADDR_W-1:OFFSET_BITS];
    assign rd_la   = rd_addr_i[ADDR_W-1:OFFSET_BITS];
    assign head_la = ent_la[int'(head)*LA_W +: LA_W];
    assign unused_offset_bits = ^{push_addr_i[OFFSET_BITS-1:0], rd_addr_i[OFFSET_BITS-1:0]};

    assign full_o  = (count == CNT_W'(WB_DEPTH));
    assign empty_o = (count == '0);

    assign wr_done = (state == WB_WRITE) && mem_ack_i;
    assign rd_done = (state == WB_READ) && mem_ack_i;

    // ------------------------------------------------------------------
    // Push path
    // ------------------------------------------------------------------
`ifdef DCACHE_WB_COALESCE_EN
    logic [WB_DEPTH-1:0] coal_mask;
    logic [PTR_W-1:0]    coal_idx;

    // The head is off-limits once its write is issued or about to be.
    always_comb begin
        coal_mask = ent_vld;
        if ((state == WB_WRITE) || start_wr) begin
            coal_mask[head] = 1'b0;
        end
    end

    dcache_wb_match #(
        .DEPTH (WB_DEPTH),
        .LA_W  (LA_W),
        .PTR_W (PTR_W)
    ) u_coal_match (
        .valid      (coal_mask),
        .line_addrs (ent_la),
        .tail       (tail),
        .key        (push_la),
        .hit        (coal_hit),
        .idx        (coal_idx)
    );
`else
    assign coal_hit = 1'b0;
`endif

    assign push_merge = push_i && coal_hit;
    assign push_alloc = push_i && !coal_hit && !full_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld <= '0;
            ent_la  <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (push_alloc) begin
                ent_vld[tail]                   <= 1'b1;
                ent_la[int'(tail)*LA_W +: LA_W] <= push_la;
                tail                            <= tail + 1'b1;
            end
            if (wr_done) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            count <= count + CNT_W'(push_alloc) - CNT_W'(wr_done);
        end
    end

    always_ff @(posedge clk) begin
        if (push_alloc) begin
            ent_dat[tail] <= push_data_i;
        end
`ifdef DCACHE_WB_COALESCE_EN
        if (push_merge) begin
            ent_dat[coal_idx] <= push_data_i;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Fill lookup: buffered entries plus a same-cycle push (the youngest)
    // ------------------------------------------------------------------
    dcache_wb_match #(
        .DEPTH (WB_DEPTH),
        .LA_W  (LA_W),
        .PTR_W (PTR_W)
    ) u_rd_match (
        .valid      (ent_vld),
        .line_addrs (ent_la),
        .tail       (tail),
        .key        (rd_la),
        .hit        (buf_hit),
        .idx        (buf_idx)
    );

    assign rd_take  = rd_req_i && !pend_vld;
    assign push_fwd = (push_alloc || push_merge) && (push_la == rd_la);
    assign rd_hit   = rd_take && (push_fwd || buf_hit);
    assign fwd_dat  = push_fwd ? push_data_i : ent_dat[buf_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld   <= 1'b0;
            pend_la    <= '0;
            rd_valid_o <= 1'b0;
            rd_fwd_o   <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_hit || rd_done;
            rd_fwd_o   <= rd_hit;
            if (rd_hit) begin
                rd_data_o <= fwd_dat;
            end else if (rd_done) begin
                rd_data_o <= mem_rdata_i;
            end
            if (rd_take && !rd_hit) begin
                pend_vld <= 1'b1;
                pend_la  <= rd_la;
            end else if (rd_done) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory port arbiter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_wr  = 1'b0;
        start_rd  = 1'b0;
        unique case (state)
            WB_IDLE: begin
                // Fills win unless the buffer is full or a flush is running.
                if (pend_vld && !(full_o || drain_i)) begin
                    state_nxt = WB_READ;
                    start_rd  = 1'b1;
                end else if (count != '0) begin
                    state_nxt = WB_WRITE;
                    start_wr  = 1'b1;
                end
            end
            WB_WRITE: begin
                if (mem_ack_i) begin
                    state_nxt = WB_IDLE;
                end
            end
            WB_READ: begin
                if (mem_ack_i) begin
                    state_nxt = WB_IDLE;
                end
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (start_wr) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= {head_la, {OFFSET_BITS{1'b0}}};
            mem_wdata_o <= ent_dat[head];
        end else if (start_rd) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {pend_la, {OFFSET_BITS{1'b0}}};
        end else if (wr_done || rd_done) begin
            mem_req_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed scenarios plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_dcache_wb_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int LW    = 128;
    localparam int OB    = 4;
    localparam int LAW   = AW - OB;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_i;
    logic [AW-1:0] push_addr_i;
    logic [LW-1:0] push_data_i;
    logic          full_o;
    logic          empty_o;
    logic          rd_req_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_valid_o;
    logic [LW-1:0] rd_data_o;
    logic          rd_fwd_o;
    logic          drain_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_wdata_o;
    logic [LW-1:0] mem_rdata_i;
    logic          mem_ack_i;

    always #5 clk = ~clk;

    dcache_wb_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_i),
        .push_addr_i (push_addr_i),
        .push_data_i (push_data_i),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .rd_req_i    (rd_req_i),
        .rd_addr_i   (rd_addr_i),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_fwd_o    (rd_fwd_o),
        .drain_i     (drain_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    typedef struct packed {
        logic [LAW-1:0] la;
        logic [LW-1:0]  d;
    } line_t;

    typedef struct packed {
        bit             fwd;
        logic [LAW-1:0] la;
        logic [LW-1:0]  d;
    } rd_exp_t;

    int checks = 0;
    int errors = 0;

    line_t   buf_q[$];      // buffered lines, oldest first
    line_t   wr_exp[$];     // writes not yet issued to memory, in order
    rd_exp_t rd_exp[$];     // fill responses still owed
    int      txn_log[$];    // 1 = write, 2 = read, in issue order
    logic [LW-1:0] mem [bit [LAW-1:0]];

    bit             rd_busy;
    bit             hold_ack;
    bit             in_txn;
    int             dly;
    int             dly_min = 0;
    int             dly_max = 3;
    bit             eff_wr;
    bit             eff_rd;
    logic [LAW-1:0] eff_la;
    logic [LW-1:0]  eff_dat;

    function automatic logic [LW-1:0] mem_get(logic [LAW-1:0] la);
        if (mem.exists(la)) return mem[la];
        return {4{la, 4'hD}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        buf_q.delete();
        wr_exp.delete();
        rd_exp.delete();
        rd_busy   = 1'b0;
        in_txn    = 1'b0;
        eff_wr    = 1'b0;
        eff_rd    = 1'b0;
        mem_ack_i = 1'b0;
    endtask

    // One clock: DUT samples at posedge, then memory responder and occupancy check at negedge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        if (eff_wr) begin
            mem[eff_la] = eff_dat;
            void'(buf_q.pop_front());
            eff_wr = 1'b0;
        end
        if (eff_rd) begin
            rd_busy = 1'b0;
            eff_rd  = 1'b0;
        end
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
        end else if (mem_req_o && !hold_ack) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                dly    = $urandom_range(dly_min, dly_max);
            end
            if (dly == 0) begin
                in_txn      = 1'b0;
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_get(mem_addr_o[AW-1:OB]);
                if (mem_we_o) begin
                    eff_wr  = 1'b1;
                    eff_la  = mem_addr_o[AW-1:OB];
                    eff_dat = mem_wdata_o;
                end else begin
                    eff_rd = 1'b1;
                end
            end else begin
                dly--;
            end
        end
        chk("full_o", full_o, buf_q.size() == DEPTH);
        chk("empty_o", empty_o, buf_q.size() == 0);
        push_i   = 1'b0;
        rd_req_i = 1'b0;
    endtask

    task automatic drive(bit p, logic [AW-1:0] pa, logic [LW-1:0] pd, bit r, logic [AW-1:0] ra);
        bit             acc;
        bit             head_busy;
        int             mi;
        int             found;
        logic [LAW-1:0] pla;
        logic [LAW-1:0] rla;
        rd_exp_t        e;
        acc = 1'b0;
        mi  = -1;
        pla = pa[AW-1:OB];
        rla = ra[AW-1:OB];
        head_busy = (mem_req_o && mem_we_o) ||
                    (!mem_req_o && buf_q.size() > 0 &&
                     (!rd_busy || buf_q.size() == DEPTH || drain_i));
`ifdef DCACHE_WB_COALESCE_EN
        for (int i = buf_q.size() - 1; i >= 0; i--) begin
            if (mi < 0 && buf_q[i].la == pla && (i > 0 || !head_busy)) mi = i;
        end
`endif
        if (p) begin
            if (mi >= 0) begin
                int wi;
                acc = 1'b1;
                buf_q[mi].d = pd;
                wi = mi - (buf_q.size() - wr_exp.size());
                if (wi >= 0) wr_exp[wi].d = pd;
            end else if (buf_q.size() < DEPTH) begin
                acc = 1'b1;
                buf_q.push_back('{la: pla, d: pd});
                wr_exp.push_back('{la: pla, d: pd});
            end
        end
        if (r && !rd_busy) begin
            found = -1;
            for (int i = 0; i < buf_q.size(); i++) begin
                if (buf_q[i].la == rla) found = i;
            end
            if (acc && pla == rla) begin
                e = '{fwd: 1'b1, la: rla, d: pd};
            end else if (found >= 0) begin
                e = '{fwd: 1'b1, la: rla, d: buf_q[found].d};
            end else begin
                e = '{fwd: 1'b0, la: rla, d: '0};
                rd_busy = 1'b1;
            end
            rd_exp.push_back(e);
        end
        push_i      = p;
        push_addr_i = pa;
        push_data_i = pd;
        rd_req_i    = r;
        rd_addr_i   = ra;
        cycle();
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic settle(string name, int budget);
        int n;
        n = 0;
        while ((buf_q.size() != 0 || rd_busy || rd_exp.size() != 0 || mem_req_o) && n < budget) begin
            idle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    // Monitor: checks every memory transaction start and every fill response.
    initial begin : monitor
        bit      prev_req;
        line_t   w;
        rd_exp_t r;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (mem_req_o && !prev_req) begin
                    if (mem_we_o) begin
                        txn_log.push_back(1);
                        if (wr_exp.size() == 0) begin
                            chk("unexpected_mem_write", 1'b1, 1'b0);
                        end else begin
                            w = wr_exp.pop_front();
                            chk("mem_wr_addr", mem_addr_o, {w.la, 4'h0});
                            chk("mem_wdata", mem_wdata_o, w.d);
                        end
                    end else begin
                        txn_log.push_back(2);
                        if (rd_exp.size() == 0 || rd_exp[0].fwd) begin
                            chk("unexpected_mem_read", 1'b1, 1'b0);
                        end else begin
                            chk("mem_rd_addr", mem_addr_o, {rd_exp[0].la, 4'h0});
                        end
                    end
                end
                prev_req = mem_req_o;
                if (rd_valid_o) begin
                    if (rd_exp.size() == 0) begin
                        chk("unexpected_rd_valid", 1'b1, 1'b0);
                    end else begin
                        r = rd_exp.pop_front();
                        chk("rd_fwd", rd_fwd_o, r.fwd);
                        chk("rd_data", rd_data_o, r.fwd ? r.d : mem_get(r.la));
                    end
                end
            end
        end
    end

    initial begin : stim
        int base;
        rst         = 1'b1;
        push_i      = 1'b0;
        push_addr_i = '0;
        push_data_i = '0;
        rd_req_i    = 1'b0;
        rd_addr_i   = '0;
        drain_i     = 1'b0;
        mem_rdata_i = '0;
        model_clear();
        hold_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_full", full_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_rd_valid", rd_valid_o, 1'b0);
        rst = 1'b0;

        // Reset in the middle of a write.
        hold_ack = 1'b1;
        drive(1'b1, 32'h0000_5550, rand_line(), 1'b0, '0);
        idle();
        chk("pre_rst_mem_req", mem_req_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_req", mem_req_o, 1'b0);
        chk("arst_mem_we", mem_we_o, 1'b0);
        chk("arst_mem_addr", mem_addr_o, '0);
        chk("arst_mem_wdata", mem_wdata_o, '0);
        chk("arst_empty", empty_o, 1'b1);
        chk("arst_full", full_o, 1'b0);
        chk("arst_rd_valid", rd_valid_o, 1'b0);
        chk("arst_rd_fwd", rd_fwd_o, 1'b0);
        chk("arst_rd_data", rd_data_o, '0);
        model_clear();
        @(negedge clk);
        rst      = 1'b0;
        hold_ack = 1'b0;

        // Basic drain with a 3-cycle memory.
        dly_min = 3;
        dly_max = 3;
        drive(1'b1, 32'h0000_1234, {4{32'hAAAA_AAAA}}, 1'b0, '0);
        settle("basic_drain", 40);
        chk("basic_empty", empty_o, 1'b1);
        dly_min = 0;
        dly_max = 3;

        // Fill up, drop a fifth push, then drain across the pointer wrap.
        hold_ack = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h0000_6000 + 32'(i) * 32'h10, rand_line(), 1'b0, '0);
        chk("full_after_4", full_o, 1'b1);
        drive(1'b1, 32'h0000_6F00, rand_line(), 1'b0, '0);
        hold_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 7) drive(1'b1, 32'h0000_7000 + 32'(i) * 32'h10, rand_line(), 1'b0, '0);
            else idle();
        end
        settle("wrap_drain", 100);

        // Forwarding from a buffered line; no memory read may appear.
        hold_ack = 1'b1;
        drive(1'b1, 32'h0000_2000, {4{32'hD00D_F00D}}, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 32'h0000_2008);
        idle();
        hold_ack = 1'b0;
        settle("fwd", 40);

        // Arbitration: fill read slots in between writes unless draining.
        for (int pass = 0; pass < 2; pass++) begin
            base     = txn_log.size();
            drain_i  = (pass == 1);
            hold_ack = 1'b1;
            drive(1'b1, 32'h0000_3100, rand_line(), 1'b0, '0);
            drive(1'b1, 32'h0000_3200, rand_line(), 1'b0, '0);
            drive(1'b0, '0, '0, 1'b1, 32'h0000_3000);
            hold_ack = 1'b0;
            for (int n = 0; n < 40 && buf_q.size() != 0; n++) idle();
            drain_i = 1'b0;
            settle("arb", 40);
            if (txn_log.size() >= base + 3) begin
                chk("arb_order0", txn_log[base], 1);
                chk("arb_order1", txn_log[base + 1], pass == 0 ? 2 : 1);
                chk("arb_order2", txn_log[base + 2], pass == 0 ? 1 : 2);
            end else begin
                chk("arb_txn_count", txn_log.size() - base, 3);
            end
        end

        // Random traffic over a few lines to get hits, misses and full cycles.
        for (int c = 0; c < 2000; c++) begin
            logic [AW-1:0] pa;
            logic [AW-1:0] ra;
            if ($urandom_range(0, 19) == 0) drain_i = ~drain_i;
            pa = {20'h00001, 4'($urandom_range(0, 7)), 4'($urandom)} ;
            ra = {20'h00001, 4'($urandom_range(0, 9)), 4'($urandom)};
            drive($urandom_range(0, 9) < 4, pa, rand_line(), $urandom_range(0, 3) == 0, ra);
        end
        drain_i = 1'b0;
        settle("random_drain", 400);
        chk("final_empty", empty_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
